// File: rtl/sdp_stream_fifo_pkg.sv
// sdp_stream_fifo shared types and defaults.
// Registered status flag bundle for the FIFO.
package sdp_stream_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_ALMOST_FULL = 12;

  typedef struct packed {
    logic in_ready;
    logic out_valid;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/sdp_stream_fifo_if.sv
// Valid/ready stream bundle.
// master drives data/valid, slave drives ready.
interface sdp_stream_fifo_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/sdp_stream_fifo_ram.sv
// Distributed simple-dual-port RAM.
// Synchronous write, asynchronous read.
module simple_dual_port_ram_reg0 #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          wclock,
  input  logic          wenable,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  // write port; contents are never cleared
  always_ff @(posedge wclock) begin
    if (wenable) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sdp_stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO.
// Flags and level are registered from next-state pointers.
module sdp_stream_fifo
  import sdp_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL = DEF_ALMOST_FULL
) (
  input  logic                clock,
  input  logic                resetn,
  sdp_stream_fifo_if.slave    in_s,
  sdp_stream_fifo_if.master   out_s,
  output logic [ADDR_WIDTH:0] level,
  output logic                almost_full
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH  = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL);

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_n, rptr_n, lvl_n;
  logic [PW-1:0] lvl_q;
  fifo_flags_t   flags, flags_n;
  logic          push, pop;
  logic [DATA_WIDTH-1:0] rdata;

  assign push = in_s.valid & flags.in_ready;
  assign pop  = flags.out_valid & out_s.ready;

  assign wptr_n = wptr + PW'(push);
  assign rptr_n = rptr + PW'(pop);
  assign lvl_n  = wptr_n - rptr_n;

  // next-state flags from next-state level
  always_comb begin
    flags_n.in_ready    = (lvl_n != DEPTH);
    flags_n.out_valid   = (lvl_n != '0);
    flags_n.almost_full = (lvl_n >= AF_LVL);
  end

  // pointers, level and flags; in_ready held low in reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      lvl_q <= '0;
      flags <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      lvl_q <= lvl_n;
      flags <= flags_n;
    end
  end

  simple_dual_port_ram_reg0 #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_ram (
    .wclock  (clock),
    .wenable (push),
    .waddr   (wptr[ADDR_WIDTH-1:0]),
    .wdata   (in_s.data),
    .raddr   (rptr[ADDR_WIDTH-1:0]),
    .rdata   (rdata)
  );

  assign in_s.ready  = flags.in_ready;
  assign out_s.valid = flags.out_valid;
  assign out_s.data  = rdata;
  assign level       = lvl_q;
  assign almost_full = flags.almost_full;

`ifdef FORMAL
  logic past_ok;

  // marks at least one clocked cycle out of reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) past_ok <= 1'b0;
    else         past_ok <= 1'b1;
  end

  // level bounds and flag consistency
  always_comb begin
    if (resetn) begin
      assert (lvl_q <= DEPTH);
      assert (!(flags.out_valid && lvl_q == '0));
      if (past_ok) assert (flags.in_ready == (lvl_q != DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_sdp_stream_fifo.sv
// Directed vectors, corner sequences and a queue-model stress
// run for sdp_stream_fifo (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_sdp_stream_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] level;
  logic af;

  always #5 clk = ~clk;

  sdp_stream_fifo_if #(.DW(8)) in_if ();
  sdp_stream_fifo_if #(.DW(8)) out_if ();

  sdp_stream_fifo #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .ALMOST_FULL (12)
  ) dut (
    .clock       (clk),
    .resetn      (rst_n),
    .in_s        (in_if),
    .out_s       (out_if),
    .level       (level),
    .almost_full (af)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       eir;
    logic       eov;
    int         elvl;
    logic       eaf;
    logic [7:0] edat;
  } vec_t;

  vec_t vt [8];
  logic [7:0] q [$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d,
                       input logic rdy);
    in_if.valid  = iv;
    in_if.data   = d;
    out_if.ready = rdy;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, base + 8'(k), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input int n, input logic [7:0] base,
                       input string nm);
    for (int k = 0; k < n; k++) begin
      chk(nm, int'(out_if.data), int'(base + 8'(k)));
      drive(1'b0, 8'h00, 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk({nm, "_empty"}, int'(out_if.valid), 0);
  endtask

  initial begin
    vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1, 1'b0, 8'hA5};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[3] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1, 1'b0, 8'h11};
    vt[4] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1, 1'b0, 8'h22};
    vt[5] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 2, 1'b0, 8'h22};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 8'h33};
    vt[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00};

    // reset held with in_valid high
    drive(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ir", int'(in_if.ready), 0);
      chk("rst_ov", int'(out_if.valid), 0);
      chk("rst_lvl", int'(level), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ir_pre", int'(in_if.ready), 0);
    step();
    chk("rel_ir", int'(in_if.ready), 1);
    chk("rel_lvl", int'(level), 0);
    chk("rel_ov", int'(out_if.valid), 0);
    drive(1'b0, 8'h00, 1'b0);

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].rdy);
      step();
      chk($sformatf("v%0d_ir", i), int'(in_if.ready), int'(vt[i].eir));
      chk($sformatf("v%0d_ov", i), int'(out_if.valid), int'(vt[i].eov));
      chk($sformatf("v%0d_lvl", i), int'(level), vt[i].elvl);
      chk($sformatf("v%0d_af", i), int'(af), int'(vt[i].eaf));
      if (vt[i].eov)
        chk($sformatf("v%0d_dat", i), int'(out_if.data),
            int'(vt[i].edat));
    end
    drive(1'b0, 8'h00, 1'b0);

    // fill to full and drain, three times to wrap pointers
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) begin
        drive(1'b1, 8'(k), 1'b0);
        step();
        chk("fill_lvl", int'(level), k + 1);
        chk("fill_af", int'(af), (k + 1 >= 12) ? 1 : 0);
        chk("fill_ir", int'(in_if.ready), (k == 15) ? 0 : 1);
      end
      for (int k = 0; k < 16; k++) begin
        chk("drain_dat", int'(out_if.data), k);
        drive(1'b0, 8'h00, 1'b1);
        step();
        if (k == 0) chk("drain_ir", int'(in_if.ready), 1);
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("drain_lvl", int'(level), 0);
      chk("drain_ov", int'(out_if.valid), 0);
    end

    // simultaneous push/pop at level 5
    fill(5, 8'h40);
    chk("sim_lvl0", int'(level), 5);
    for (int i = 0; i < 20; i++) begin
      chk("sim_dat", int'(out_if.data), 'h40 + i);
      drive(1'b1, 8'(8'h45 + i), 1'b1);
      step();
      chk("sim_lvl", int'(level), 5);
    end
    drive(1'b0, 8'h00, 1'b0);
    drain(5, 8'h54, "sim_tail");

    // push refused while full, pop accepted
    fill(16, 8'h80);
    chk("full_ir", int'(in_if.ready), 0);
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("full_lvl", int'(level), 15);
    chk("full_ir2", int'(in_if.ready), 1);
    drain(15, 8'h81, "full_tail");

    // asynchronous reset mid-operation
    fill(9, 8'h20);
    chk("mr_lvl0", int'(level), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ov", int'(out_if.valid), 0);
    chk("mr_lvl", int'(level), 0);
    chk("mr_af", int'(af), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_ir", int'(in_if.ready), 1);
    fill(1, 8'h3C);
    fill(1, 8'h3D);
    chk("mr_lvl2", int'(level), 2);
    drain(2, 8'h3C, "mr_dat");

    // randomized stress against a queue model
    q.delete();
    for (int ph = 0; ph < 3; ph++) begin
      int div, dor;
      div = (ph == 0) ? 30 : (ph == 1) ? 70 : 100;
      dor = (ph == 0) ? 100 : (ph == 1) ? 70 : 30;
      for (int c = 0; c < 3300; c++) begin
        logic iv, rdy, mpush, mpop;
        logic [7:0] d;
        iv  = ($urandom_range(99) < div);
        rdy = ($urandom_range(99) < dor);
        d   = 8'($urandom);
        mpush = iv && (q.size() != 16);
        mpop  = rdy && (q.size() != 0);
        drive(iv, d, rdy);
        step();
        if (mpop) void'(q.pop_front());
        if (mpush) q.push_back(d);
        chk("st_lvl", int'(level), q.size());
        chk("st_ir", int'(in_if.ready), (q.size() != 16) ? 1 : 0);
        chk("st_ov", int'(out_if.valid), (q.size() != 0) ? 1 : 0);
        chk("st_af", int'(af), (q.size() >= 12) ? 1 : 0);
        if (q.size() != 0)
          chk("st_dat", int'(out_if.data), int'(q[0]));
      end
    end
    drive(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
